adma_dm_rd_host: RTL

//  Read-side AXI master host of the ADMA datamover. Counterpart of the write host.

---
 rtl/adma_dm_rd_host.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/adma_dm_rd_host.sv
// adma_dm_rd_host: read-side AXI master host of the ADMA datamover.
// It issues AR bursts from descriptors, routes R beats to channels by RID, and reports per-channel done and source error.
// Optional feature ADMA_RD_RLAST_CHK_EN: per-channel beat counters flag a misplaced RLAST as a source error.
module adma_dm_rd_host #(
    parameter int DMA_CHN_NUM    = 4,
    parameter int SRC_ADDR_W     = 32,
    parameter int MST_ID_W       = 5,
    parameter int ATX_LEN_W      = 8,
    parameter int ATX_RESP_W     = 2,
    parameter int ATX_SRC_DATA_W = 256,
    parameter int ATX_NUM_OSTD   = DMA_CHN_NUM,
    parameter int DMA_CHN_NUM_W  = $clog2(DMA_CHN_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DMA_CHN_NUM_W-1:0]  atx_chn_id,
    input  logic [MST_ID_W-1:0]       atx_arid,
    input  logic [SRC_ADDR_W-1:0]     atx_araddr,
    input  logic [ATX_LEN_W-1:0]      atx_arlen,
    input  logic [1:0]                atx_arburst,
    input  logic                      atx_vld,
    output logic                      atx_rdy,
    output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
    output logic [DMA_CHN_NUM_W-1:0]  atx_rdata_chn_id,
    output logic                      atx_rdata_last,
    output logic                      atx_rdata_vld,
    input  logic                      atx_rdata_rdy,
    input  logic [MST_ID_W-1:0]       atx_id [0:DMA_CHN_NUM-1],
    output logic                      atx_src_err [0:DMA_CHN_NUM-1],
    output logic                      atx_done [0:DMA_CHN_NUM-1],
    output logic [MST_ID_W-1:0]       m_arid_o,
    output logic [SRC_ADDR_W-1:0]     m_araddr_o,
    output logic [ATX_LEN_W-1:0]      m_arlen_o,
    output logic [1:0]                m_arburst_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [MST_ID_W-1:0]       m_rid_i,
    input  logic [ATX_SRC_DATA_W-1:0] m_rdata_i,
    input  logic [ATX_RESP_W-1:0]     m_rresp_i,
    input  logic                      m_rlast_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o
);
    localparam int OSTD_W = ATX_LEN_W + 1;

    logic                     arvalid_q, arvalid_d;
    logic [MST_ID_W-1:0]      arid_q;
    logic [SRC_ADDR_W-1:0]    araddr_q;
    logic [ATX_LEN_W-1:0]     arlen_q;
    logic [1:0]               arburst_q;
    logic [OSTD_W-1:0]        ostd_q, ostd_d;
    logic [DMA_CHN_NUM-1:0]   err_q, err_d, done_q, done_d, serr_q, serr_d;
    logic                     hit, accept, beat_hs, last_hs, beat_err;
    logic [DMA_CHN_NUM_W-1:0] chn;

    // RID lookup: scanning downwards lets the lowest matching channel win
    always_comb begin
        hit = 1'b0;
        chn = '0;
        for (int k = DMA_CHN_NUM - 1; k >= 0; k--)
            if (m_rid_i == atx_id[k]) begin
                hit = 1'b1;
                chn = DMA_CHN_NUM_W'(k);
            end
    end

    assign accept           = atx_vld & atx_rdy;
    assign atx_rdy          = (~arvalid_q | m_arready_i) & (ostd_q < OSTD_W'(ATX_NUM_OSTD));
    assign m_rready_o       = atx_rdata_rdy | ~hit;
    assign atx_rdata_vld    = m_rvalid_i & hit;
    assign atx_rdata        = m_rdata_i;
    assign atx_rdata_last   = m_rlast_i;
    assign atx_rdata_chn_id = chn;
    assign beat_hs          = m_rvalid_i & hit & atx_rdata_rdy;
    assign last_hs          = beat_hs & m_rlast_i;
    assign m_arvalid_o      = arvalid_q;
    assign m_arid_o         = arid_q;
    assign m_araddr_o       = araddr_q;
    assign m_arlen_o        = arlen_q;
    assign m_arburst_o      = arburst_q;

`ifdef ADMA_RD_RLAST_CHK_EN
    logic [ATX_LEN_W-1:0] len_q [DMA_CHN_NUM];
    logic [ATX_LEN_W-1:0] bcnt_q [DMA_CHN_NUM];

    assign beat_err = (m_rresp_i != '0) | (m_rlast_i != (bcnt_q[chn] == len_q[chn]));

    // Per-channel expected length and running beat count; a last beat restarts the count
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < DMA_CHN_NUM; k++) begin
                len_q[k]  <= '0;
                bcnt_q[k] <= '0;
            end
        end else begin
            if (accept) len_q[atx_chn_id] <= atx_arlen;
            if (beat_hs) bcnt_q[chn] <= m_rlast_i ? '0 : bcnt_q[chn] + 1'b1;
        end
`else
    assign beat_err = m_rresp_i != '0;
`endif

    // Next state: AR slot, outstanding count, sticky error and registered completion
    always_comb begin
        arvalid_d = accept | (arvalid_q & ~m_arready_i);
        ostd_d    = ostd_q + OSTD_W'(accept) - OSTD_W'(last_hs);
        done_d    = '0;
        serr_d    = '0;
        err_d     = err_q;
        for (int k = 0; k < DMA_CHN_NUM; k++) begin
            done_d[k] = last_hs & (chn == DMA_CHN_NUM_W'(k));
            serr_d[k] = done_d[k] & (err_q[k] | beat_err);
            err_d[k]  = done_d[k] ? 1'b0 : err_q[k] | (beat_hs & (chn == DMA_CHN_NUM_W'(k)) & beat_err);
        end
    end

    // Fan the packed completion flags out to the per-channel ports
    always_comb
        for (int k = 0; k < DMA_CHN_NUM; k++) begin
            atx_done[k]    = done_q[k];
            atx_src_err[k] = serr_q[k];
        end

    // State registers; reset drops all in-flight bursts without completion
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            ostd_q    <= '0;
            err_q     <= '0;
            done_q    <= '0;
            serr_q    <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            ostd_q    <= ostd_d;
            err_q     <= err_d;
            done_q    <= done_d;
            serr_q    <= serr_d;
            if (accept) begin
                arid_q    <= atx_arid;
                araddr_q  <= atx_araddr;
                arlen_q   <= atx_arlen;
                arburst_q <= atx_arburst;
            end
        end
endmodule
